// File: rtl/wm_pkg.sv
// wm_pkg: phase-timer state encoding and default timing constants shared with the wash FSM
package wm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} wm_state_t;
  localparam int WM_TICK_DIV  = 50_000_000;
  localparam int WM_CYCLE_SEC = 600;
  localparam int WM_SPIN_SEC  = 300;
endpackage

// File: rtl/wm_tick_gen.sv
// wm_tick_gen: one-second prescaler that emits a single-cycle tick on its last count
module wm_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] cnt;
  assign tick = en && cnt == PW'(TICK_DIV - 1);
  // clear wins over counting; the count wraps to 0 on the tick
  always_ff @(posedge clk) begin
    if (!rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + PW'(1);
  end
endmodule

// File: rtl/wm_phase_timer.sv
// wm_phase_timer: times wash/spin motor runs and holds the time-out until motor release; pause support under WM_TIMER_PAUSE_EN
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV  = WM_TICK_DIV,
  parameter int CNT_W     = 12,
  parameter int CYCLE_SEC = WM_CYCLE_SEC,
  parameter int SPIN_SEC  = WM_SPIN_SEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             motor_on,
  input  logic             spin_mode,
  input  logic             pause,
  output logic             cycle_time_out,
  output logic             spin_time_out,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);
  localparam logic [CNT_W-1:0] CYCLE_N = CNT_W'(CYCLE_SEC);
  localparam logic [CNT_W-1:0] SPIN_N  = CNT_W'(SPIN_SEC);
  wm_state_t state;
  logic mode, tick, hold, active;
`ifdef WM_TIMER_PAUSE_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold = 1'b0;
`endif
  assign active = state == RUN || state == PAUSED;
  wm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (!hold),
    .clr (!(active && motor_on)),
    .tick(tick)
  );
  // run-phase FSM with the seconds counter and registered handshakes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      mode           <= 1'b0;
      busy           <= 1'b0;
      remaining      <= '0;
      cycle_time_out <= 1'b0;
      spin_time_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (motor_on) begin
          state     <= RUN;
          mode      <= spin_mode;
          busy      <= 1'b1;
          remaining <= spin_mode ? SPIN_N : CYCLE_N;
        end
        RUN, PAUSED: begin
          if (!motor_on) begin
            state     <= IDLE;
            busy      <= 1'b0;
            remaining <= '0;
          end else if (tick) begin
            remaining <= remaining <= CNT_W'(1) ? '0 : remaining - CNT_W'(1);
            if (remaining <= CNT_W'(1)) begin
              state          <= EXPIRED;
              busy           <= 1'b0;
              cycle_time_out <= !mode;
              spin_time_out  <= mode;
            end else state <= RUN;
          end else state <= hold ? PAUSED : RUN;
        end
        EXPIRED: if (!motor_on) begin
          state          <= IDLE;
          cycle_time_out <= 1'b0;
          spin_time_out  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wm_phase_timer.sv
// tb_wm_phase_timer: directed checks of load, countdown, expiry, hold, abort, pause and mid-run reset
module tb_wm_phase_timer;
  logic clk = 1'b0, rst = 1'b0, motor_on = 1'b0, spin_mode = 1'b0, pause = 1'b0;
  logic cycle_time_out, spin_time_out, busy;
  logic [11:0] remaining;
  int n_checks = 0, n_fail = 0, ed = 0;
`ifdef WM_TIMER_PAUSE_EN
  localparam int PX = 17;
`else
  localparam int PX = 12;
`endif
  wm_phase_timer #(.TICK_DIV(4), .CNT_W(12), .CYCLE_SEC(3), .SPIN_SEC(2)) dut (
    .clk(clk), .rst(rst), .motor_on(motor_on), .spin_mode(spin_mode), .pause(pause),
    .cycle_time_out(cycle_time_out), .spin_time_out(spin_time_out),
    .busy(busy), .remaining(remaining)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, ed, got, exp);
    end
  endtask
  task automatic goto(input int e);
    while (ed < e) begin
      @(posedge clk);
      #1;
      ed++;
    end
  endtask
  task automatic outs(input string tag, input int c, input int s, input int b, input int r);
    check({tag, ".cto"}, 32'(cycle_time_out), c);
    check({tag, ".sto"}, 32'(spin_time_out), s);
    check({tag, ".busy"}, 32'(busy), b);
    check({tag, ".rem"}, 32'(remaining), r);
  endtask
  task automatic load(input logic sm);
    motor_on = 1'b1;
    spin_mode = sm;
    ed = -1;
    goto(0);
  endtask
  task automatic release_motor(input string tag);
    motor_on = 1'b0;
    goto(ed + 1);
    outs(tag, 0, 0, 0, 0);
  endtask
  initial begin
    goto(3);
    outs("reset", 0, 0, 0, 0);
    rst = 1'b1;
    goto(5);
    outs("idle", 0, 0, 0, 0);
    load(1'b0);
    outs("wash0", 0, 0, 1, 3);
    goto(4);  outs("wash4", 0, 0, 1, 2);
    goto(8);  outs("wash8", 0, 0, 1, 1);
    goto(11); outs("wash11", 0, 0, 1, 1);
    goto(12); outs("wash12", 1, 0, 0, 0);
    goto(17); outs("hold17", 1, 0, 0, 0);
    release_motor("wrel");
    load(1'b1);
    outs("spin0", 0, 0, 1, 2);
    goto(3);
    spin_mode = 1'b0;
    goto(4);  outs("spin4", 0, 0, 1, 1);
    goto(7);  outs("spin7", 0, 0, 1, 1);
    goto(8);  outs("spin8", 0, 1, 0, 0);
    release_motor("srel");
    load(1'b0);
    goto(5);  outs("ab5", 0, 0, 1, 2);
    motor_on = 1'b0;
    goto(6);  outs("ab6", 0, 0, 0, 0);
    goto(8);
    motor_on = 1'b1;
    goto(9);  outs("ab9", 0, 0, 1, 3);
    goto(20); outs("ab20", 0, 0, 1, 1);
    goto(21); outs("ab21", 1, 0, 0, 0);
    release_motor("arel");
    load(1'b0);
    goto(4);
    pause = 1'b1;
    goto(7);  check("pz7.busy", 32'(busy), 1);
    goto(9);
    pause = 1'b0;
    goto(PX - 1); check("pz.pre", 32'(cycle_time_out), 0);
    goto(PX); outs("pz.exp", 1, 0, 0, 0);
    release_motor("prel");
    load(1'b0);
    goto(6);
    rst = 1'b0;
    goto(7);  outs("mrst7", 0, 0, 0, 0);
    rst = 1'b1;
    goto(8);  outs("mrst8", 0, 0, 1, 3);
    goto(19); check("mrst19", 32'(cycle_time_out), 0);
    goto(20); outs("mrst20", 1, 0, 0, 0);
    release_motor("mrel");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wm_phase_timer.md
# wm_phase_timer

Phase timer for the washing-machine controller. It sits directly upstream of the wash FSM and produces the `cycle_time_out` and `spin_time_out` handshakes that the FSM waits on.
- It times each motor run, wash cycle or spin, from the FSM's `motor_on` output.
- It holds the timeout flag until the FSM releases the motor.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick; must be ≥ 2.
- `CNT_W`, default 12: width of the seconds counter.
- `CYCLE_SEC`, default 600: wash-cycle duration in seconds; 1 ≤ value < 2^CNT_W.
- `SPIN_SEC`, default 300: spin duration in seconds; 1 ≤ value < 2^CNT_W.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-low (0 = reset).
- `motor_on`  in  1  level from the wash FSM; high while the drum must turn.
- `spin_mode`  in  1  selects the duration: 1 = spin, 0 = wash cycle; sampled only at load.
- `pause`  in  1  holds the count; functional only when the pause feature is compiled in.
- `cycle_time_out`  out  1  wash cycle expired; registered level.
- `spin_time_out`  out  1  spin expired; registered level.
- `busy`  out  1  high in RUN and PAUSED.
- `remaining`  out  CNT_W  whole seconds left.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED.
- The `mode` flop stores `spin_mode` at load.
- IDLE:
  - If `motor_on`=1, go to RUN.
  - Load `remaining` = `spin_mode` ? SPIN_SEC : CYCLE_SEC.
  - Clear the prescaler and latch `mode`.
- RUN:
  - Each edge increments the prescaler.
  - When the prescaler = TICK_DIV-1: it wraps to 0 and `remaining` decrements.
  - If `remaining` was 1 at that wrap, go to EXPIRED and set the time-out output selected by `mode`.
- Abort:
  - `motor_on`=0 in RUN or PAUSED sends the block to IDLE.
  - `remaining` and the prescaler clear to 0; no time-out is asserted.
  - Abort has priority over tick and pause.
- EXPIRED:
  - The time-out output stays high while `motor_on`=1.
  - `motor_on`=0 clears it and returns to IDLE.
  - There is no auto-reload while the block is held in EXPIRED.
- `spin_mode` changes after load are ignored.
- `cycle_time_out` and `spin_time_out` are never high together.
- Counter width:
  - `remaining` never underflows; it stops at 0.
  - The prescaler is $clog2(TICK_DIV) bits wide.
- Reset-mode priority: reset overrides every condition.

## Timing
- Reset values:
  - state = IDLE.
  - `cycle_time_out` = 0, `spin_time_out` = 0, `busy` = 0, `remaining` = 0, prescaler = 0.
- Load: `motor_on` is sampled high at edge k.
  - At edge k: `busy`=1 and `remaining`=N.
  - At edge k + j·TICK_DIV: `remaining` = N-j.
  - At edge k + N·TICK_DIV: the time-out rises, together with `remaining`=0 and `busy`=0.
- Release: `motor_on` is sampled low at edge m; the time-out and `busy` are 0 after edge m.
- Restart: a new load needs `motor_on` high at an edge while in IDLE. The minimum gap between runs is one low cycle.
- Mid-run reset: all outputs are at reset values after the edge. If `motor_on` is still high when `rst` releases, a fresh load occurs on the first non-reset edge.

## Configuration
- Macro: `WM_TIMER_PAUSE_EN`.
- Defined:
  - `pause`=1 in RUN moves to PAUSED; the prescaler and `remaining` freeze.
  - `pause`=0 returns to RUN and counting resumes from the frozen values.
  - Each pause cycle delays expiry by exactly one cycle.
  - `pause` is ignored in IDLE and EXPIRED.
- Undefined: `pause` is ignored and PAUSED is unreachable.

## Structure
- Package `wm_pkg`:
  - state enum for this block.
  - default constants `WM_TICK_DIV`, `WM_CYCLE_SEC`, `WM_SPIN_SEC`.
  - shared with the wash FSM.
- Sub-module `wm_tick_gen`:
  - prescaler with `en` and `clr` inputs.
  - emits a one-cycle `tick` when the count = TICK_DIV-1.
- The top level holds the FSM and the seconds counter.

## Test plan
Bench parameters: TICK_DIV=4, CYCLE_SEC=3, SPIN_SEC=2.
- Wash run: `rst` released, `motor_on`=1 and `spin_mode`=0 at edge 0 → `remaining` 3/2/1/0 at edges 0/4/8/12; `cycle_time_out`=1 from edge 12; `spin_time_out` stays 0.
- Spin run: `spin_mode`=1 at load, toggled at edge 3 → `spin_time_out` at edge 8; toggle has no effect.
- Abort: `motor_on` low at edge 6 → IDLE after edge 6, `remaining`=0, no time-out; `motor_on` high at edge 9 → reload to 3, expiry at edge 21.
- Pause, macro defined: `pause` high edges 5–9 → expiry at edge 17. Macro undefined: same stimulus expires at edge 12.
- Hold and release: after expiry, `motor_on` held 5 cycles → `cycle_time_out` stays 1; clears on the edge that samples `motor_on`=0.
- Mid-run reset: `rst`=0 at edge 7 → all outputs 0 after it; `rst`=1 with `motor_on` still high → reload, expiry 12 edges later.
